// File: rtl/bsg_sync_gray_ptr_receiver.sv
// Destination-side consumer of a synchronized gray write pointer: capture, decode,
// local read pointer with pop handshake, flop-launched gray read pointer, sticky error.
module bsg_sync_gray_ptr_receiver #(
   parameter int width_p = 4
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic [width_p-1:0] gray_ptr_i,
   input  logic               yumi_i,
   output logic               v_o,
   output logic [width_p-1:0] count_o,
   output logic [width_p-1:0] rd_ptr_o,
   output logic [width_p-1:0] rd_ptr_gray_o,
   output logic               err_o
);

   logic [width_p-1:0] r_gray;
   logic [width_p-1:0] r_wr_bin;
   logic [width_p-1:0] r_rd_ptr;
   logic [width_p-1:0] r_rd_gray;
   logic               r_err;

   logic [width_p-1:0] w_dec;
   logic [width_p-1:0] w_count;
   logic [width_p-1:0] w_diff;
   logic [width_p-1:0] w_rd_nxt;
   logic [width_p-1:0] w_rd_gray_nxt;
   logic               w_v;
   logic               w_pop;
   logic               w_underflow;
   logic               w_bad_step;

   // Each binary bit is the XOR of all gray bits at or above it.
   genvar gi;
   generate
      for (gi = 0; gi < width_p; gi++) begin : g_dec
         assign w_dec[gi] = ^r_gray[width_p-1:gi];
      end
   endgenerate

   assign w_count       = r_wr_bin - r_rd_ptr;
   assign w_v           = (w_count != '0);
   assign w_pop         = yumi_i & w_v;
   assign w_underflow   = yumi_i & ~w_v;
   assign w_rd_nxt      = r_rd_ptr + 1'b1;
   assign w_rd_gray_nxt = w_rd_nxt ^ (w_rd_nxt >> 1);

   // More than one bit flipped: clearing the lowest set bit leaves something behind.
   assign w_diff     = gray_ptr_i ^ r_gray;
   assign w_bad_step = ((w_diff & (w_diff - 1'b1)) != '0);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_gray    <= '0;
         r_wr_bin  <= '0;
         r_rd_ptr  <= '0;
         r_rd_gray <= '0;
         r_err     <= 1'b0;
      end else begin
         r_gray   <= gray_ptr_i;
         r_wr_bin <= w_dec;
         if (w_pop) begin
            r_rd_ptr  <= w_rd_nxt;
            r_rd_gray <= w_rd_gray_nxt;
         end
         if (w_bad_step || w_underflow)
            r_err <= 1'b1;
      end
   end

   assign v_o           = w_v;
   assign count_o       = w_count;
   assign rd_ptr_o      = r_rd_ptr;
   assign rd_ptr_gray_o = r_rd_gray;
   assign err_o         = r_err;

endmodule
